// File: rtl/blaster_uart_rx_gen_if.sv
// Purpose: receive-side bundle between the UART receiver and the blaster command handler.
// Latency: none (wires only).
// Backpressure: the consumer pops with i_rd while o_valid is high; if it stops popping, the FIFO fills and frames are dropped.
interface blaster_uart_rx_gen_if #(
   parameter int DATA_BITS = 8
);
   logic                 i_rd;
   logic                 i_clr;
   logic                 o_valid;
   logic [DATA_BITS-1:0] o_data;
   logic                 o_parity_err;
   logic                 o_frame_err;
   logic                 o_rdy;
   logic                 o_break;
   logic                 o_overrun;
   logic                 o_busy;

   // receiver side
   modport master (
      input  i_rd, i_clr,
      output o_valid, o_data, o_parity_err, o_frame_err,
      output o_rdy, o_break, o_overrun, o_busy
   );

   // command handler side
   modport slave (
      output i_rd, i_clr,
      input  o_valid, o_data, o_parity_err, o_frame_err,
      input  o_rdy, o_break, o_overrun, o_busy
   );
endinterface

// File: rtl/blaster_uart_rx_gen.sv
// Purpose: UART receiver with 3-sample majority voting, parity/framing/break detection and a show-ahead receive FIFO.
// Latency: an entry is pushed one clock after the mid-point decision on the final stop bit, and is visible on o_valid the clock after that.
// Backpressure: a frame that arrives while the FIFO is full is dropped and sets the sticky o_overrun flag.
module blaster_uart_rx_gen #(
   parameter int CLKS_PER_BIT = 55,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                  i_Clock,
   input  logic                  reset,
   input  logic                  i_rx,
   blaster_uart_rx_gen_if.master bus
);
   localparam int          AW        = $clog2(FIFO_DEPTH);
   localparam int          EW        = DATA_BITS + 2;
   localparam logic [10:0] LAST      = 11'(CLKS_PER_BIT - 1);
   localparam logic [10:0] MID       = 11'((CLKS_PER_BIT - 1) / 2);
   localparam logic [10:0] MID_M1    = MID - 11'd1;
   localparam logic [10:0] MID_P1    = MID + 11'd1;
   localparam logic [3:0]  LAST_DBIT = 4'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BRK_WAIT
   } state_t;

   logic                 sync1_q, rxs_q;
   state_t               state_q;
   logic [10:0]          cnt_q;
   logic [3:0]           bit_idx_q;
   logic                 stop_idx_q;
   logic                 smp0_q, smp1_q, smp2_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bit_q, par_err_q, frm_err_q;
   logic                 push_q, brk_q;
   logic [EW-1:0]        push_dat_q;

   logic                 cnt_wrap, maj_reg, maj_now, par_exp, stop_final;

   assign cnt_wrap   = (cnt_q == LAST);
   // Vote over the three registered samples, used at the end of a bit period.
   assign maj_reg    = (smp0_q & smp1_q) | (smp0_q & smp2_q) | (smp1_q & smp2_q);
   // Vote at the third sample point itself, where the third sample is still on rxs.
   assign maj_now    = (smp0_q & smp1_q) | (smp0_q & rxs_q) | (smp1_q & rxs_q);
   assign par_exp    = (PARITY == 1) ? ~(^shift_q) : (^shift_q);
   assign stop_final = (STOP_BITS == 1) ? 1'b1 : stop_idx_q;

   // Two-flop synchroniser; it resets to the idle (high) line level.
   always_ff @(posedge i_Clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         rxs_q   <= 1'b1;
      end else begin
         sync1_q <= i_rx;
         rxs_q   <= sync1_q;
      end
   end

   // Frame state machine: bit timing, majority sampling, frame decode and the push/break pulses.
   always_ff @(posedge i_Clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         bit_idx_q  <= '0;
         stop_idx_q <= 1'b0;
         smp0_q     <= 1'b1;
         smp1_q     <= 1'b1;
         smp2_q     <= 1'b1;
         shift_q    <= '0;
         par_bit_q  <= 1'b0;
         par_err_q  <= 1'b0;
         frm_err_q  <= 1'b0;
         push_q     <= 1'b0;
         brk_q      <= 1'b0;
         push_dat_q <= '0;
      end else begin
         push_q <= 1'b0;
         brk_q  <= 1'b0;
         if (state_q != S_IDLE && state_q != S_BRK_WAIT) begin
            cnt_q <= cnt_wrap ? 11'd0 : cnt_q + 11'd1;
            if (cnt_q == MID_M1) smp0_q <= rxs_q;
            if (cnt_q == MID)    smp1_q <= rxs_q;
            if (cnt_q == MID_P1) smp2_q <= rxs_q;
         end
         case (state_q)
            S_IDLE: begin
               cnt_q      <= '0;
               bit_idx_q  <= '0;
               stop_idx_q <= 1'b0;
               par_bit_q  <= 1'b0;
               par_err_q  <= 1'b0;
               frm_err_q  <= 1'b0;
               if (!rxs_q) state_q <= S_START;
            end
            S_START: begin
               // A start bit that votes high at its centre was a glitch.
               if (cnt_q == MID_P1 && maj_now) state_q <= S_IDLE;
               else if (cnt_wrap)              state_q <= S_DATA;
            end
            S_DATA: begin
               if (cnt_wrap) begin
                  shift_q   <= {maj_reg, shift_q[DATA_BITS-1:1]};
                  bit_idx_q <= bit_idx_q + 4'd1;
                  if (bit_idx_q == LAST_DBIT) state_q <= (PARITY != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               if (cnt_wrap) begin
                  par_bit_q <= maj_reg;
                  par_err_q <= (maj_reg != par_exp);
                  state_q   <= S_STOP;
               end
            end
            S_STOP: begin
               if (!stop_final) begin
                  if (cnt_wrap) begin
                     if (!maj_reg) frm_err_q <= 1'b1;
                     stop_idx_q <= 1'b1;
                  end
               end else if (cnt_q == MID_P1) begin
                  // Decide half-way through the last stop bit so a following start bit is not missed.
                  if (shift_q == '0 && !par_bit_q && !maj_now) begin
                     brk_q   <= 1'b1;
                     state_q <= S_BRK_WAIT;
                  end else begin
                     push_q     <= 1'b1;
                     push_dat_q <= {frm_err_q | ~maj_now, par_err_q, shift_q};
                     state_q    <= S_IDLE;
                  end
               end
            end
            S_BRK_WAIT: begin
               if (rxs_q) state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Receive FIFO: show-ahead, with the pointer MSB telling full from empty.
   logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] head;
   logic          ovr_q, ovr_d;
   logic          empty, full, pop, push_ok;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop     = bus.i_rd && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push_ok = push_q && (!full || pop);

   // Next pointers and the sticky overrun; a new drop wins over a clear in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
      ovr_d    = ovr_q;
      if (bus.i_clr)           ovr_d = 1'b0;
      if (push_q && !push_ok)  ovr_d = 1'b1;
   end

   // Pointer and overrun registers.
   always_ff @(posedge i_Clock or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         ovr_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         ovr_q    <= ovr_d;
      end
   end

   // Entry storage; cleared on reset so the head reads as zero until the first push.
   always_ff @(posedge i_Clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      end else if (push_ok) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_q;
      end
   end

   assign head             = mem_q[rd_ptr_q[AW-1:0]];
   assign bus.o_valid      = !empty;
   assign bus.o_data       = head[DATA_BITS-1:0];
   assign bus.o_parity_err = head[DATA_BITS];
   assign bus.o_frame_err  = head[DATA_BITS+1];
   assign bus.o_rdy        = push_ok;
   assign bus.o_break      = brk_q;
   assign bus.o_overrun    = ovr_q;
   assign bus.o_busy       = (state_q != S_IDLE);
endmodule

// File: tb/tb_blaster_uart_rx_gen.sv
// Purpose: bench for blaster_uart_rx_gen; an 8E1 instance carries most traffic and an 8N1 instance covers the basic and break cases.
// Latency: the expected push cycle is derived from the synchroniser depth, START entry and the stop-bit mid point.
// Backpressure: covers FIFO fill, overrun, clear, and a pop coincident with a push into a full FIFO.
module tb_blaster_uart_rx_gen;
   localparam int CPB    = 16;
   localparam int FD     = 4;
   localparam int NB_E   = 11;
   localparam int NB_N   = 10;
   localparam int MIDP1  = (CPB - 1) / 2 + 1;
   // Clocks from driving the start bit low to the cycle in which o_rdy is visible.
   localparam int PUSH_E = 4 + CPB * (NB_E - 1) + MIDP1;
   localparam int PUSH_N = 4 + CPB * (NB_N - 1) + MIDP1;

   logic clk = 1'b0;
   logic rst_n, rx_e, rx_n;
   int   n_vec = 0, n_err = 0;
   int   rdy_e = 0, rdy_n = 0, brk_e = 0, brk_n = 0;
   logic probe_rdy, probe_vld, probe_vld_nxt;

   blaster_uart_rx_gen_if #(.DATA_BITS(8)) bus_e ();
   blaster_uart_rx_gen_if #(.DATA_BITS(8)) bus_n ();

   blaster_uart_rx_gen #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(FD))
      u_dut_e (.i_Clock(clk), .reset(rst_n), .i_rx(rx_e), .bus(bus_e));
   blaster_uart_rx_gen #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(FD))
      u_dut_n (.i_Clock(clk), .reset(rst_n), .i_rx(rx_n), .bus(bus_n));

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-way through the low clock phase.
   always @(negedge clk) begin
      #2;
      if (bus_e.o_rdy)   rdy_e++;
      if (bus_n.o_rdy)   rdy_n++;
      if (bus_e.o_break) brk_e++;
      if (bus_n.o_break) brk_n++;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] frame_e(input logic [7:0] d, input logic p, input logic s);
      return {5'b0, s, p, d, 1'b0};
   endfunction

   function automatic logic [15:0] frame_n(input logic [7:0] d, input logic s);
      return {6'b0, s, d, 1'b0};
   endfunction

   task automatic idle(input int n);
      rx_e = 1'b1;
      rx_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Drives nb bit periods; glitch_c flips one clock; at probe_c optionally pops (act 1) or clears (act 2) and samples o_rdy/o_valid.
   task automatic send(input bit which, input logic [15:0] bits, input int nb, input int glitch_c,
                       input int probe_c, input int act);
      logic v;
      for (int c = 0; c < nb * CPB; c++) begin
         v = bits[4'(c / CPB)];
         if (c == glitch_c) v = ~v;
         if (which) begin
            rx_e = v;
            bus_e.i_rd  = (c == probe_c && act == 1);
            bus_e.i_clr = (c == probe_c && act == 2);
         end else begin
            rx_n = v;
            bus_n.i_rd  = (c == probe_c && act == 1);
            bus_n.i_clr = (c == probe_c && act == 2);
         end
         if (c == probe_c) begin
            #1;
            probe_rdy = which ? bus_e.o_rdy : bus_n.o_rdy;
            probe_vld = which ? bus_e.o_valid : bus_n.o_valid;
         end
         if (c == probe_c + 1) probe_vld_nxt = which ? bus_e.o_valid : bus_n.o_valid;
         @(negedge clk);
      end
      bus_e.i_rd = 1'b0; bus_e.i_clr = 1'b0;
      bus_n.i_rd = 1'b0; bus_n.i_clr = 1'b0;
   endtask

   task automatic pop(input bit which);
      if (which) bus_e.i_rd = 1'b1; else bus_n.i_rd = 1'b1;
      @(negedge clk);
      bus_e.i_rd = 1'b0;
      bus_n.i_rd = 1'b0;
   endtask

   task automatic chk_head(input bit which, input logic [7:0] d, input logic pe, input logic fe, input string nm);
      if (which) begin
         chk({nm, "_vld"}, 32'(bus_e.o_valid), 32'd1);
         chk({nm, "_dat"}, 32'(bus_e.o_data), 32'(d));
         chk({nm, "_pe"},  32'(bus_e.o_parity_err), 32'(pe));
         chk({nm, "_fe"},  32'(bus_e.o_frame_err), 32'(fe));
      end else begin
         chk({nm, "_vld"}, 32'(bus_n.o_valid), 32'd1);
         chk({nm, "_dat"}, 32'(bus_n.o_data), 32'(d));
         chk({nm, "_pe"},  32'(bus_n.o_parity_err), 32'(pe));
         chk({nm, "_fe"},  32'(bus_n.o_frame_err), 32'(fe));
      end
   endtask

   function automatic logic [31:0] all_outs(input bit which);
      if (which)
         return 32'({bus_e.o_valid, bus_e.o_rdy, bus_e.o_break, bus_e.o_overrun, bus_e.o_busy,
                     bus_e.o_parity_err, bus_e.o_frame_err, bus_e.o_data});
      return 32'({bus_n.o_valid, bus_n.o_rdy, bus_n.o_break, bus_n.o_overrun, bus_n.o_busy,
                  bus_n.o_parity_err, bus_n.o_frame_err, bus_n.o_data});
   endfunction

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       s;
      int         glitch;
      logic [7:0] exp_d;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   initial begin
      vec_t       tbl[10];
      logic [9:0] q_m[$];
      logic [9:0] e;
      logic [7:0] d;
      logic       p, s;
      int         g, base_rdy, base_brk, exp_rdy, exp_brk;

      // Even-parity 8E1 vectors; expected flags worked out by hand.
      tbl[0] = '{8'hA5, 1'b0, 1'b1, -1,              8'hA5, 1'b0, 1'b0};
      tbl[1] = '{8'h03, 1'b1, 1'b1, -1,              8'h03, 1'b1, 1'b0};
      tbl[2] = '{8'h03, 1'b0, 1'b1, -1,              8'h03, 1'b0, 1'b0};
      tbl[3] = '{8'h55, 1'b0, 1'b0, -1,              8'h55, 1'b0, 1'b1};
      tbl[4] = '{8'h80, 1'b0, 1'b1, -1,              8'h80, 1'b1, 1'b0};
      tbl[5] = '{8'h80, 1'b1, 1'b1, -1,              8'h80, 1'b0, 1'b0};
      tbl[6] = '{8'h5A, 1'b0, 1'b1, CPB * 1 + 8,     8'h5A, 1'b0, 1'b0};
      tbl[7] = '{8'hFF, 1'b0, 1'b1, CPB * 8 + 7,     8'hFF, 1'b0, 1'b0};
      tbl[8] = '{8'h00, 1'b1, 1'b1, -1,              8'h00, 1'b1, 1'b0};
      tbl[9] = '{8'h00, 1'b1, 1'b0, -1,              8'h00, 1'b1, 1'b1};

      rst_n = 1'b1; rx_e = 1'b1; rx_n = 1'b1;
      bus_e.i_rd = 1'b0; bus_e.i_clr = 1'b0;
      bus_n.i_rd = 1'b0; bus_n.i_clr = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_outs_e", all_outs(1), 32'd0);
      chk("rst_outs_n", all_outs(0), 32'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      idle(4);
      chk("post_rst_outs_e", all_outs(1), 32'd0);
      chk("post_rst_outs_n", all_outs(0), 32'd0);

      // Basic 8N1 frame with exact push timing.
      send(0, frame_n(8'hA5, 1'b1), NB_N, -1, PUSH_N, 0);
      chk("basic_rdy_at_push", 32'(probe_rdy), 32'd1);
      chk("basic_vld_at_push", 32'(probe_vld), 32'd0);
      chk("basic_vld_after",   32'(probe_vld_nxt), 32'd1);
      idle(2 * CPB);
      chk_head(0, 8'hA5, 1'b0, 1'b0, "basic");
      pop(0);
      chk("basic_vld_popped", 32'(bus_n.o_valid), 32'd0);

      // Table of 8E1 frames: parity, framing, majority-vote corruption.
      base_rdy = rdy_e;
      foreach (tbl[i]) begin
         send(1, frame_e(tbl[i].d, tbl[i].p, tbl[i].s), NB_E, tbl[i].glitch, PUSH_E, 0);
         chk($sformatf("tbl%0d_rdy", i), 32'(probe_rdy), 32'd1);
         chk($sformatf("tbl%0d_vld_late", i), 32'(probe_vld_nxt), 32'd1);
         idle(2 * CPB);
         chk_head(1, tbl[i].exp_d, tbl[i].exp_pe, tbl[i].exp_fe, $sformatf("tbl%0d", i));
         pop(1);
         chk($sformatf("tbl%0d_empty", i), 32'(bus_e.o_valid), 32'd0);
      end
      chk("tbl_rdy_count", 32'(rdy_e - base_rdy), 32'd10);

      // Short low glitch on an idle line: START is entered, then abandoned.
      base_rdy = rdy_n;
      rx_n = 1'b0;
      repeat (3) @(negedge clk);
      rx_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("glitch_busy", 32'(bus_n.o_busy), 32'd1);
      idle(3 * CPB);
      chk("glitch_idle", 32'(bus_n.o_busy), 32'd0);
      chk("glitch_nopush", 32'(rdy_n - base_rdy), 32'd0);

      // Break: line low for two frame times.
      base_rdy = rdy_n; base_brk = brk_n;
      rx_n = 1'b0;
      repeat (2 * NB_N * CPB) @(negedge clk);
      chk("brk_pulses", 32'(brk_n - base_brk), 32'd1);
      chk("brk_nopush", 32'(rdy_n - base_rdy), 32'd0);
      chk("brk_wait_busy", 32'(bus_n.o_busy), 32'd1);
      chk("brk_vld", 32'(bus_n.o_valid), 32'd0);
      rx_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("brk_released", 32'(bus_n.o_busy), 32'd0);

      // Overrun: five frames, no pops.
      base_rdy = rdy_e;
      for (int k = 1; k <= 5; k++) begin
         send(1, frame_e(8'(k), ^(8'(k)), 1'b1), NB_E, -1, -1, 0);
         idle(2 * CPB);
      end
      chk("ovr_set", 32'(bus_e.o_overrun), 32'd1);
      chk("ovr_accepted", 32'(rdy_e - base_rdy), 32'd4);
      chk_head(1, 8'h01, 1'b0, 1'b0, "ovr_head");
      bus_e.i_clr = 1'b1;
      @(negedge clk);
      bus_e.i_clr = 1'b0;
      chk("ovr_cleared", 32'(bus_e.o_overrun), 32'd0);
      // Push into the full FIFO with a pop in the very same cycle.
      send(1, frame_e(8'h05, ^(8'h05), 1'b1), NB_E, -1, PUSH_E, 1);
      chk("coinc_rdy", 32'(probe_rdy), 32'd1);
      idle(2 * CPB);
      chk("coinc_no_ovr", 32'(bus_e.o_overrun), 32'd0);
      for (int k = 2; k <= 5; k++) begin
         chk_head(1, 8'(k), 1'b0, 1'b0, $sformatf("coinc_q%0d", k));
         pop(1);
      end
      chk("coinc_empty", 32'(bus_e.o_valid), 32'd0);
      // Clear coinciding with a fresh drop keeps the flag set.
      for (int k = 1; k <= 5; k++) begin
         send(1, frame_e(8'(8'h10 + k), ^(8'(8'h10 + k)), 1'b1), NB_E, -1, (k == 5) ? PUSH_E : -1, (k == 5) ? 2 : 0);
         idle(2 * CPB);
      end
      chk("clr_vs_drop_rdy", 32'(probe_rdy), 32'd0);
      chk("clr_vs_drop_ovr", 32'(bus_e.o_overrun), 32'd1);
      chk_head(1, 8'h11, 1'b0, 1'b0, "clr_vs_drop_head");

      // Reset in the 4th data bit, with the FIFO full and overrun set.
      base_rdy = rdy_e; base_brk = brk_e;
      send(1, frame_e(8'h3C, 1'b0, 1'b1), 4, -1, -1, 0);
      rx_e = 1'b1;
      repeat (8) @(negedge clk);
      chk("mid_busy", 32'(bus_e.o_busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_outs_e", all_outs(1), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      idle(2 * CPB);
      chk("mid_post_outs_e", all_outs(1), 32'd0);
      chk("mid_post_outs_n", all_outs(0), 32'd0);
      chk("mid_no_pulses", 32'(rdy_e - base_rdy + brk_e - base_brk), 32'd0);
      send(1, frame_e(8'h3C, 1'b0, 1'b1), NB_E, -1, -1, 0);
      idle(2 * CPB);
      chk_head(1, 8'h3C, 1'b0, 1'b0, "after_rst");
      pop(1);

      // Random 8E1 traffic against a queue model of the frame rules.
      base_rdy = rdy_e; base_brk = brk_e; exp_rdy = 0; exp_brk = 0;
      for (int i = 0; i < 40; i++) begin
         d = 8'($urandom_range(0, 255));
         p = (^d) ^ ($urandom_range(0, 3) == 0);
         s = ($urandom_range(0, 3) != 0);
         if (i % 10 == 5) begin d = 8'h00; p = 1'b0; s = 1'b0; end
         g = CPB * int'($urandom_range(1, 8)) + int'($urandom_range(7, 9));
         if (d == 8'h00 && !p && !s) exp_brk++;
         else begin
            q_m.push_back({~s, p != (^d), d});
            exp_rdy++;
         end
         send(1, frame_e(d, p, s), NB_E, g, -1, 0);
         idle(2 * CPB);
         if (q_m.size() == FD || $urandom_range(0, 1) == 1) begin
            while (q_m.size() > 0) begin
               e = q_m.pop_front();
               chk_head(1, e[7:0], e[8], e[9], $sformatf("rnd%0d", i));
               pop(1);
            end
            chk($sformatf("rnd%0d_empty", i), 32'(bus_e.o_valid), 32'd0);
         end
      end
      while (q_m.size() > 0) begin
         e = q_m.pop_front();
         chk_head(1, e[7:0], e[8], e[9], "rnd_tail");
         pop(1);
      end
      repeat (4) @(negedge clk);
      chk("rnd_rdy_count", 32'(rdy_e - base_rdy), 32'(exp_rdy));
      chk("rnd_brk_count", 32'(brk_e - base_brk), 32'(exp_brk));
      chk("rnd_no_ovr", 32'(bus_e.o_overrun), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
